// File: rtl/pc_unit_if.sv
// Fetch-side bus of the program-counter unit: redirect/RAS requests in, fetch pc out.
interface pc_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall;
  logic                trap_req;
  logic                br_valid;
  logic [PC_WIDTH-1:0] br_target;
  logic                jmp_valid;
  logic [PC_WIDTH-1:0] jmp_target;
  logic                call;
  logic [PC_WIDTH-1:0] link_pc;
  logic                ret;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_valid;
  logic                flush;
  logic                ras_empty;

  // Pipeline side: raises requests, consumes the fetch address.
  modport master (
    output stall, trap_req, br_valid, br_target, jmp_valid, jmp_target,
           call, link_pc, ret,
    input  pc, pc_valid, flush, ras_empty
  );

  // PC unit side.
  modport slave (
    input  stall, trap_req, br_valid, br_target, jmp_valid, jmp_target,
           call, link_pc, ret,
    output pc, pc_valid, flush, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-pc selection with a circular
// return-address stack, redirect flush and an INIT/RUN start-up state.
module pc_unit #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h100),
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_unit_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(RAS_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic                pc_valid_q;
  logic                flush_q, flush_next;

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr;
  logic [PTR_W-1:0]    ras_top_idx;
  logic [CNT_W-1:0]    ras_cnt;
  logic                ras_is_empty;
  logic                push, pop, ras_clear;

  assign ras_top_idx  = ras_ptr - PTR_W'(1);
  assign ras_is_empty = (ras_cnt == '0);

  // Next-state, next-pc and RAS control; redirects beat stall, decode requests
  // only act when neither trap nor branch claims the cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    flush_next = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ras_clear  = 1'b0;
    case (state)
      ST_INIT: state_next = ST_RUN;
      ST_RUN: begin
        if (bus.trap_req) begin
          pc_next    = TRAP_VECTOR & ALIGN_MASK;
          flush_next = 1'b1;
          ras_clear  = 1'b1;
        end else if (bus.br_valid) begin
          pc_next    = bus.br_target & ALIGN_MASK;
          flush_next = 1'b1;
        end else begin
          push = bus.jmp_valid && bus.call;
          pop  = bus.ret && !ras_is_empty;
          if (bus.jmp_valid) begin
            pc_next    = bus.jmp_target & ALIGN_MASK;
            flush_next = 1'b1;
          end else if (pop) begin
            pc_next    = ras_mem[ras_top_idx] & ALIGN_MASK;
            flush_next = 1'b1;
          end else if (!bus.stall) begin
            pc_next = pc_q + INC;
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // State, pc and flush registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      pc_valid_q <= (state_next == ST_RUN);
      flush_q    <= flush_next;
    end
  end

  // RAS pointer and occupancy; a full push overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_clear) begin
      ras_cnt <= '0;
    end else if (push && !pop) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      ras_cnt <= (ras_cnt == CNT_FULL) ? CNT_FULL : ras_cnt + CNT_W'(1);
    end else if (pop && !push) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // RAS storage; simultaneous pop and push replaces the top entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (push && pop) begin
        ras_mem[ras_top_idx] <= bus.link_pc;
      end else if (push) begin
        ras_mem[ras_ptr] <= bus.link_pc;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.flush     = flush_q;
  assign bus.ras_empty = ras_is_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  pc_unit_if #(.PC_WIDTH(32)) bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.stall      = 1'b0;
    bus.trap_req   = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_target  = '0;
    bus.jmp_valid  = 1'b0;
    bus.jmp_target = '0;
    bus.call       = 1'b0;
    bus.link_pc    = '0;
    bus.ret        = 1'b0;
  endtask

  // One rising edge, then sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); else passed++;
    checks++; if (bus.pc_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.pc_valid); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", bus.flush); else passed++;
    checks++; if (bus.ras_empty !== 1'b1) $display("FAIL reset_ras_empty got %b exp 1", bus.ras_empty); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pc_valid !== 1'b0) $display("FAIL reset_hold_valid got %b exp 0", bus.pc_valid); else passed++;
    rst = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h0) $display("FAIL rel_edge1_pc got %h exp %h", bus.pc, 32'h0); else passed++;
    checks++; if (bus.pc_valid !== 1'b1) $display("FAIL rel_edge1_valid got %b exp 1", bus.pc_valid); else passed++;
    step();
    checks++; if (bus.pc !== 32'h4) $display("FAIL rel_edge2_pc got %h exp %h", bus.pc, 32'h4); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL rel_edge2_flush got %b exp 0", bus.flush); else passed++;
    step();
    checks++; if (bus.pc !== 32'h8) $display("FAIL rel_edge3_pc got %h exp %h", bus.pc, 32'h8); else passed++;
  endtask

  task automatic test_priority();
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h300; bus.call = 1'b1; bus.link_pc = 32'h10;
    step();
    checks++; if (bus.pc !== 32'h300) $display("FAIL call_pc got %h exp %h", bus.pc, 32'h300); else passed++;
    checks++; if (bus.ras_empty !== 1'b0) $display("FAIL call_ras_empty got %b exp 0", bus.ras_empty); else passed++;
    bus.trap_req = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h40;
    bus.jmp_target = 32'h80; bus.link_pc = 32'h20;
    step();
    checks++; if (bus.pc !== 32'h100) $display("FAIL prio_pc got %h exp %h", bus.pc, 32'h100); else passed++;
    checks++; if (bus.flush !== 1'b1) $display("FAIL prio_flush got %b exp 1", bus.flush); else passed++;
    checks++; if (bus.ras_empty !== 1'b1) $display("FAIL prio_ras_cleared got %b exp 1", bus.ras_empty); else passed++;
    idle();
    step();
    checks++; if (bus.pc !== 32'h104) $display("FAIL post_trap_pc got %h exp %h", bus.pc, 32'h104); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL post_trap_flush got %b exp 0", bus.flush); else passed++;
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 32'h104) $display("FAIL stall_pc[%0d] got %h exp %h", i, bus.pc, 32'h104); else passed++;
    end
    checks++; if (bus.flush !== 1'b0) $display("FAIL stall_flush got %b exp 0", bus.flush); else passed++;
    bus.br_valid = 1'b1; bus.br_target = 32'h203;
    step();
    checks++; if (bus.pc !== 32'h200) $display("FAIL stall_br_pc got %h exp %h", bus.pc, 32'h200); else passed++;
    checks++; if (bus.flush !== 1'b1) $display("FAIL stall_br_flush got %b exp 1", bus.flush); else passed++;
    idle();
    step();
    checks++; if (bus.pc !== 32'h204) $display("FAIL stall_release_pc got %h exp %h", bus.pc, 32'h204); else passed++;
  endtask

  task automatic test_ras();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h50; exp_ret[1] = 32'h40; exp_ret[2] = 32'h30; exp_ret[3] = 32'h20;
    for (int i = 1; i <= 5; i++) begin
      bus.jmp_valid = 1'b1; bus.jmp_target = 32'h1000; bus.call = 1'b1; bus.link_pc = 32'(i * 16);
      step();
      checks++; if (bus.pc !== 32'h1000) $display("FAIL ras_call_pc[%0d] got %h exp %h", i, bus.pc, 32'h1000); else passed++;
    end
    idle();
    bus.ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.pc !== exp_ret[i]) $display("FAIL ras_ret_pc[%0d] got %h exp %h", i, bus.pc, exp_ret[i]); else passed++;
      checks++; if (bus.flush !== 1'b1) $display("FAIL ras_ret_flush[%0d] got %b exp 1", i, bus.flush); else passed++;
    end
    checks++; if (bus.ras_empty !== 1'b1) $display("FAIL ras_drained got %b exp 1", bus.ras_empty); else passed++;
    step();
    checks++; if (bus.pc !== 32'h24) $display("FAIL ras_empty_ret_pc got %h exp %h", bus.pc, 32'h24); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL ras_empty_ret_flush got %b exp 0", bus.flush); else passed++;
    idle();
  endtask

  task automatic test_ras_mixed();
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h500; bus.call = 1'b1; bus.link_pc = 32'h10;
    step();
    checks++; if (bus.pc !== 32'h500) $display("FAIL mix_call_pc got %h exp %h", bus.pc, 32'h500); else passed++;
    bus.ret = 1'b1; bus.jmp_target = 32'h600; bus.link_pc = 32'h8B;
    step();
    checks++; if (bus.pc !== 32'h600) $display("FAIL mix_retjmp_pc got %h exp %h", bus.pc, 32'h600); else passed++;
    checks++; if (bus.ras_empty !== 1'b0) $display("FAIL mix_replace_empty got %b exp 0", bus.ras_empty); else passed++;
    idle();
    bus.br_valid = 1'b1; bus.br_target = 32'h900; bus.ret = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h900) $display("FAIL mix_br_ret_pc got %h exp %h", bus.pc, 32'h900); else passed++;
    checks++; if (bus.ras_empty !== 1'b0) $display("FAIL mix_br_no_pop got %b exp 0", bus.ras_empty); else passed++;
    bus.br_valid = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h88) $display("FAIL mix_ret_top_pc got %h exp %h", bus.pc, 32'h88); else passed++;
    checks++; if (bus.ras_empty !== 1'b1) $display("FAIL mix_ret_empty got %b exp 1", bus.ras_empty); else passed++;
    bus.stall = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h88) $display("FAIL mix_empty_ret_stall_pc got %h exp %h", bus.pc, 32'h88); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL mix_empty_ret_stall_flush got %b exp 0", bus.flush); else passed++;
    idle();
  endtask

  task automatic test_wrap();
    bus.br_valid = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    step();
    checks++; if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc got %h exp %h", bus.pc, 32'hFFFF_FFFC); else passed++;
    idle();
    step();
    checks++; if (bus.pc !== 32'h0) $display("FAIL wrap_pc got %h exp %h", bus.pc, 32'h0); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL wrap_flush got %b exp 0", bus.flush); else passed++;
    step();
    checks++; if (bus.pc !== 32'h4) $display("FAIL wrap_next_pc got %h exp %h", bus.pc, 32'h4); else passed++;
  endtask

  task automatic test_async_reset();
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h80; bus.call = 1'b1; bus.link_pc = 32'h44;
    step();
    checks++; if (bus.pc !== 32'h80) $display("FAIL async_setup_pc got %h exp %h", bus.pc, 32'h80); else passed++;
    checks++; if (bus.ras_empty !== 1'b0) $display("FAIL async_setup_ras got %b exp 0", bus.ras_empty); else passed++;
    idle();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h0) $display("FAIL async_pc got %h exp %h", bus.pc, 32'h0); else passed++;
    checks++; if (bus.pc_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", bus.pc_valid); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL async_flush got %b exp 0", bus.flush); else passed++;
    checks++; if (bus.ras_empty !== 1'b1) $display("FAIL async_ras got %b exp 1", bus.ras_empty); else passed++;
    bus.br_valid = 1'b1; bus.br_target = 32'h40;
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h0) $display("FAIL init_ignore_pc got %h exp %h", bus.pc, 32'h0); else passed++;
    checks++; if (bus.pc_valid !== 1'b1) $display("FAIL init_ignore_valid got %b exp 1", bus.pc_valid); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("FAIL init_ignore_flush got %b exp 0", bus.flush); else passed++;
    idle();
    step();
    checks++; if (bus.pc !== 32'h4) $display("FAIL after_init_pc got %h exp %h", bus.pc, 32'h4); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_priority();
    test_stall();
    test_ras();
    test_ras_mixed();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of all program-counter values.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h100, redirect address on trap.
REQ-004 SHALL have parameter INSTR_BYTES, default 4, sequential increment, power of two.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries, power of two >= 2.
REQ-006 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port stall  in  1  hold current pc.
REQ-009 SHALL have port trap_req  in  1  redirect to TRAP_VECTOR.
REQ-010 SHALL have ports br_valid in 1 / br_target in PC_WIDTH  execute-stage redirect.
REQ-011 SHALL have ports jmp_valid in 1 / jmp_target in PC_WIDTH  decode-stage jump.
REQ-012 SHALL have ports call in 1 / link_pc in PC_WIDTH  push link_pc to RAS (qualified by jmp_valid).
REQ-013 SHALL have port ret  in  1  decode-predicted return, target = RAS top.
REQ-014 SHALL have ports pc out PC_WIDTH, pc_valid out 1, flush out 1, ras_empty out 1.

Function
REQ-015 SHALL implement two states: INIT (entered on reset) and RUN; INIT -> RUN on first rising edge after rst deasserts; pc holds RESET_VECTOR across that edge.
REQ-016 SHALL ignore all request inputs while in INIT; pc_valid = 1 exactly when in RUN (registered).
REQ-017 SHALL select next pc in RUN by priority: trap_req > br_valid > jmp_valid > ret (RAS non-empty) > stall (hold) > pc + INSTR_BYTES.
REQ-018 SHALL let every redirect override stall.
REQ-019 SHALL compute sequential pc modulo 2^PC_WIDTH (wrap from all-ones region to 0, no flag).
REQ-020 SHALL force low log2(INSTR_BYTES) bits of every redirect target to zero.
REQ-021 SHALL assert flush (registered) for exactly one cycle following each edge at which a redirect (trap, br, jmp, ret) was taken; back-to-back redirects keep flush high.
REQ-022 SHALL update RAS only when the decode request is taken, i.e. not when trap_req or br_valid is asserted the same cycle.
REQ-023 SHALL push link_pc when call && jmp_valid is taken; on full, overwrite oldest entry (circular), count saturates at RAS_DEPTH.
REQ-024 SHALL pop on a taken ret; ret with jmp_valid uses jmp_target but still pops.
REQ-025 SHALL, on simultaneous pop and push, replace the top entry (count unchanged).
REQ-026 SHALL treat ret on empty RAS as no redirect and no pop (falls through to stall/sequential).
REQ-027 SHALL clear RAS count to 0 on taken trap_req.
REQ-028 SHALL drive ras_empty = (count == 0), combinationally from state.

Reset
REQ-029 SHALL on rst low, immediately and without clk: pc = RESET_VECTOR, pc_valid = 0, flush = 0, RAS count = 0, ras_empty = 1, state = INIT.
REQ-030 SHALL abandon any in-progress redirect/RAS update when rst asserts mid-operation; RAS entry contents need not be reset.

Verification
REQ-031 SHALL cover reset release: rst 0->1, no requests -> edge1 pc=0 pc_valid=1, edge2 pc=4, edge3 pc=8.
REQ-032 SHALL cover priority: trap_req, br_valid (br_target='h40), jmp_valid same cycle -> pc='h100, flush=1 next cycle, RAS cleared.
REQ-033 SHALL cover stall vs redirect: stall=1 three cycles -> pc constant; stall=1 with br_target='h203 -> pc='h200.
REQ-034 SHALL cover RAS: 5 calls (link 'h10,'h20,'h30,'h40,'h50), depth 4, then 5 rets -> targets 'h50,'h40,'h30,'h20, fifth ret sequential, ras_empty=1.
REQ-035 SHALL cover wrap: pc='hFFFF_FFFC, no requests -> pc=0 next cycle, flush=0.
REQ-036 SHALL cover async reset mid-run: rst low between edges with pc='h80 -> pc=0, pc_valid=0 before next edge.
